// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S DSP-mode channels.
// Holds the receive FSM state encoding and the datapath width constants
// used by the RX channel top and its per-channel deserialiser.
package i2s_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;
    localparam int OFF_W  = 9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_WS = 2'd1,
        OFFSET  = 2'd2,
        RUN     = 2'd3
    } rx_state_e;

endpackage

// File: rtl/i2s_rx_dsp_deser.sv
// Per-channel deserialiser for the DSP-mode receiver.
// Writes one serial bit per sampling edge at the bit index supplied by the
// channel controller, and presents the completed word (including the bit
// being written this edge) extended to 32 bits.
// Optional build macro: I2S_RX_SIGN_EXT_EN selects sign extension from bit
// num_bits; otherwise the word is zero-extended.
// Ports:
//   sck      : sampling clock (already edge-selected)
//   rstn     : async active-low reset
//   clr      : discard the partial word
//   wr       : write din at bit_idx this edge
//   done     : last bit of the word is written this edge; register clears
//   bit_idx  : target bit position
//   num_bits : word length minus 1
//   din      : serial data bit
//   word     : extended word as it will stand after this edge's write
module i2s_rx_dsp_deser
    import i2s_pkg::*;
(
    input  logic              sck,
    input  logic              rstn,
    input  logic              clr,
    input  logic              wr,
    input  logic              done,
    input  logic [CNT_W-1:0]  bit_idx,
    input  logic [CNT_W-1:0]  num_bits,
    input  logic              din,
    output logic [DATA_W-1:0] word
);

    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] merged;

    function automatic logic [DATA_W-1:0] extend_word(input logic [DATA_W-1:0] w,
                                                      input logic [CNT_W-1:0]  nb);
        logic [DATA_W-1:0] r;
        logic              fill;
        r = w;
`ifdef I2S_RX_SIGN_EXT_EN
        fill = w[nb];
`else
        fill = 1'b0;
`endif
        for (int i = 0; i < DATA_W; i++) begin
            if (i > int'(nb)) r[i] = fill;
        end
        return r;
    endfunction

    // A clear and a write on the same edge restart the word with this bit.
    always_comb begin
        merged = clr ? '0 : shreg;
        if (wr) merged[bit_idx] = din;
    end

    assign word = extend_word(merged, num_bits);

    always_ff @(posedge sck or negedge rstn) begin
        if (!rstn) begin
            shreg <= '0;
        end else if (done) begin
            shreg <= '0;
        end else if (clr || wr) begin
            shreg <= merged;
        end
    end

endmodule

// File: rtl/pulp_clock_inverter.sv
// Behavioural model of the clock inverter cell.
// Ports:
//   clk_i : clock in
//   clk_o : inverted clock out
module pulp_clock_inverter (
    input  logic clk_i,
    output logic clk_o
);

    assign clk_o = ~clk_i;

endmodule

// File: rtl/pulp_clock_mux2.sv
// Behavioural model of the glitch-prone 2:1 clock mux cell.
// Ports:
//   clk0_i    : clock selected when clk_sel_i = 0
//   clk1_i    : clock selected when clk_sel_i = 1
//   clk_sel_i : select
//   clk_o     : selected clock
module pulp_clock_mux2 (
    input  logic clk0_i,
    input  logic clk1_i,
    input  logic clk_sel_i,
    output logic clk_o
);

    assign clk_o = clk_sel_i ? clk1_i : clk0_i;

endmodule

// File: rtl/i2s_rx_dsp_channel.sv
// DSP-mode receive channel for the uDMA I2S peripheral.
// Waits for a one-cycle frame sync, skips a programmable bit offset, then
// deserialises back-to-back words on one or two data lines and hands them
// to the RX FIFO, channel 0 first. Everything runs on the selected sck edge.
// Optional build macro: I2S_RX_SIGN_EXT_EN (sign-extend received words).
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | disabled, all buffers and counters cleared
// WAIT_WS | enabled, waiting for the frame sync
// OFFSET  | counting sck cycles between frame sync and first data bit
// RUN     | receiving words back to back
//
// Ports:
//   sck_i, rstn_i            : bit clock, async active-low reset
//   i2s_ch0_i, i2s_ch1_i     : serial data lines
//   i2s_ws_i                 : frame-sync pulse
//   fifo_data_o/_valid_o     : output word and valid (held until accepted)
//   fifo_data_ready_i        : FIFO accept
//   fifo_err_o               : one-cycle overrun pulse
//   cfg_*                    : enable, 2-channel, word length-1, bit order,
//                              sampling edge, frame-sync offset
module i2s_rx_dsp_channel
    import i2s_pkg::*;
(
    input  logic              sck_i,
    input  logic              rstn_i,
    input  logic              i2s_ch0_i,
    input  logic              i2s_ch1_i,
    input  logic              i2s_ws_i,
    output logic [DATA_W-1:0] fifo_data_o,
    output logic              fifo_data_valid_o,
    input  logic              fifo_data_ready_i,
    output logic              fifo_err_o,
    input  logic              cfg_en_i,
    input  logic              cfg_2ch_i,
    input  logic [CNT_W-1:0]  cfg_num_bits_i,
    input  logic              cfg_lsb_first_i,
    input  logic              cfg_slave_dsp_mode_i,
    input  logic [OFF_W-1:0]  cfg_slave_dsp_offset_i
);

    logic sck_inv;
    logic sck_r;

    pulp_clock_inverter u_sck_inv (
        .clk_i (sck_i),
        .clk_o (sck_inv)
    );

    pulp_clock_mux2 u_sck_mux (
        .clk0_i    (sck_inv),
        .clk1_i    (sck_i),
        .clk_sel_i (cfg_slave_dsp_mode_i),
        .clk_o     (sck_r)
    );

    rx_state_e         state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [OFF_W-1:0]  off_cnt;
    logic              sample;
    logic              restart;
    logic [CNT_W-1:0]  eff_cnt;
    logic [CNT_W-1:0]  bit_idx;
    logic              word_done;
    logic              offset_zero;
    logic              offset_last;
    logic [DATA_W-1:0] word_ch0;
    logic [DATA_W-1:0] word_ch1;
    logic [DATA_W-1:0] pend_data;
    logic              pend_valid;
    logic              occupied;
    logic              xfer;

    assign offset_zero = (cfg_slave_dsp_offset_i == '0);
    assign offset_last = (off_cnt == cfg_slave_dsp_offset_i - 9'd1);

    always_ff @(posedge sck_r or negedge rstn_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= state_nxt;
    end

    // sample: a data bit is taken this edge. restart: a frame sync landed
    // mid-word, so the partial word is thrown away.
    always_comb begin
        state_nxt = state;
        sample    = 1'b0;
        restart   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_en_i) state_nxt = WAIT_WS;
            end
            WAIT_WS: begin
                if (i2s_ws_i) begin
                    if (offset_zero) begin
                        state_nxt = RUN;
                        sample    = 1'b1;
                    end else begin
                        state_nxt = OFFSET;
                    end
                end
            end
            OFFSET: begin
                if (offset_last) begin
                    state_nxt = RUN;
                    sample    = 1'b1;
                end
            end
            RUN: begin
                if (i2s_ws_i && (bit_cnt != '0)) begin
                    restart = 1'b1;
                    if (offset_zero) sample    = 1'b1;
                    else             state_nxt = OFFSET;
                end else begin
                    sample = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!cfg_en_i) begin
            state_nxt = IDLE;
            sample    = 1'b0;
            restart   = 1'b0;
        end
    end

    assign eff_cnt   = restart ? '0 : bit_cnt;
    assign bit_idx   = cfg_lsb_first_i ? eff_cnt : (cfg_num_bits_i - eff_cnt);
    assign word_done = sample && (eff_cnt == cfg_num_bits_i);

    always_ff @(posedge sck_r or negedge rstn_i) begin
        if (!rstn_i) begin
            bit_cnt <= '0;
            off_cnt <= '0;
        end else if (!cfg_en_i) begin
            bit_cnt <= '0;
            off_cnt <= '0;
        end else begin
            if (sample)       bit_cnt <= word_done ? '0 : (eff_cnt + 5'd1);
            else if (restart) bit_cnt <= '0;
            off_cnt <= ((state == OFFSET) && (state_nxt == OFFSET)) ? (off_cnt + 9'd1) : '0;
        end
    end

    i2s_rx_dsp_deser u_deser_ch0 (
        .sck      (sck_r),
        .rstn     (rstn_i),
        .clr      (restart || !cfg_en_i),
        .wr       (sample),
        .done     (word_done),
        .bit_idx  (bit_idx),
        .num_bits (cfg_num_bits_i),
        .din      (i2s_ch0_i),
        .word     (word_ch0)
    );

    i2s_rx_dsp_deser u_deser_ch1 (
        .sck      (sck_r),
        .rstn     (rstn_i),
        .clr      (restart || !cfg_en_i),
        .wr       (sample && cfg_2ch_i),
        .done     (word_done),
        .bit_idx  (bit_idx),
        .num_bits (cfg_num_bits_i),
        .din      (i2s_ch1_i),
        .word     (word_ch1)
    );

    // Occupancy is judged before this edge's transfer, so a word popped on
    // the same edge as a word-done still counts as an overrun.
    assign occupied = fifo_data_valid_o || pend_valid;
    assign xfer     = fifo_data_valid_o && fifo_data_ready_i;

    always_ff @(posedge sck_r or negedge rstn_i) begin
        if (!rstn_i) begin
            fifo_data_o       <= '0;
            fifo_data_valid_o <= 1'b0;
            pend_data         <= '0;
            pend_valid        <= 1'b0;
            fifo_err_o        <= 1'b0;
        end else if (!cfg_en_i) begin
            fifo_data_o       <= '0;
            fifo_data_valid_o <= 1'b0;
            pend_data         <= '0;
            pend_valid        <= 1'b0;
            fifo_err_o        <= 1'b0;
        end else begin
            fifo_err_o <= word_done && occupied;
            if (word_done && !occupied) begin
                fifo_data_o       <= word_ch0;
                fifo_data_valid_o <= 1'b1;
                if (cfg_2ch_i) begin
                    pend_data  <= word_ch1;
                    pend_valid <= 1'b1;
                end
            end else if (xfer) begin
                fifo_data_valid_o <= pend_valid;
                if (pend_valid) fifo_data_o <= pend_data;
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_dsp_channel.sv
module tb_i2s_rx_dsp_channel;

    logic        sck_i = 1'b0;
    logic        rstn_i;
    logic        i2s_ch0_i, i2s_ch1_i, i2s_ws_i;
    logic [31:0] fifo_data_o;
    logic        fifo_data_valid_o;
    logic        fifo_data_ready_i;
    logic        fifo_err_o;
    logic        cfg_en_i, cfg_2ch_i, cfg_lsb_first_i, cfg_slave_dsp_mode_i;
    logic [4:0]  cfg_num_bits_i;
    logic [8:0]  cfg_slave_dsp_offset_i;

    always #5 sck_i = ~sck_i;

    i2s_rx_dsp_channel dut (
        .sck_i                  (sck_i),
        .rstn_i                 (rstn_i),
        .i2s_ch0_i              (i2s_ch0_i),
        .i2s_ch1_i              (i2s_ch1_i),
        .i2s_ws_i               (i2s_ws_i),
        .fifo_data_o            (fifo_data_o),
        .fifo_data_valid_o      (fifo_data_valid_o),
        .fifo_data_ready_i      (fifo_data_ready_i),
        .fifo_err_o             (fifo_err_o),
        .cfg_en_i               (cfg_en_i),
        .cfg_2ch_i              (cfg_2ch_i),
        .cfg_num_bits_i         (cfg_num_bits_i),
        .cfg_lsb_first_i        (cfg_lsb_first_i),
        .cfg_slave_dsp_mode_i   (cfg_slave_dsp_mode_i),
        .cfg_slave_dsp_offset_i (cfg_slave_dsp_offset_i)
    );

`ifdef I2S_RX_SIGN_EXT_EN
    localparam logic [31:0] EXP_0800 = 32'hFFFFF800;
    localparam logic [31:0] EXP_000A = 32'hFFFFFFFA;
`else
    localparam logic [31:0] EXP_0800 = 32'h00000800;
    localparam logic [31:0] EXP_000A = 32'h0000000A;
`endif

    typedef struct {
        logic        mode;
        logic        two;
        logic        lsb;
        logic [4:0]  nb;
        int          off;
        logic [31:0] w0, w1;
        logic [31:0] e0, e1;
        int          npush;
        int          lat;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic        exp_err;
    logic [31:0] pop_q[$];
    logic [31:0] tx0[$];
    logic [31:0] tx1[$];
    int          err_pulses;
    int          ecount = 0;
    int          ws_edge = -1;
    int          first_valid = -1;
    int          rdy_mode = 0;
    int          rdy_pct = 100;
    int          rdy_on_edge = 0;

    function automatic logic [31:0] exp_word(input logic [31:0] w, input int n);
        logic [63:0] mask;
        logic [31:0] m;
        mask = (64'd1 << n) - 64'd1;
        m = w & mask[31:0];
`ifdef I2S_RX_SIGN_EXT_EN
        if (((w >> (n - 1)) & 32'd1) == 32'd1) m = m | ~mask[31:0];
`endif
        return m;
    endfunction

    function automatic logic ser_bit(input logic [31:0] w, input int j);
        int n;
        n = int'(cfg_num_bits_i) + 1;
        return cfg_lsb_first_i ? w[j] : w[n - 1 - j];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecount);
        end
    endtask

    // One sampling edge: drive inputs, advance, update the reference model
    // and compare. done marks the edge carrying the last bit of a word.
    task automatic step(input logic ws_v, input logic d0, input logic d1,
                        input logic done, input logic [31:0] w0, input logic [31:0] w1);
        logic rdy;
        logic occ;
        int   n;
        case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = ($urandom_range(99) < rdy_pct);
            2:       rdy = (ecount + 1 >= rdy_on_edge);
            default: rdy = 1'b0;
        endcase
        i2s_ws_i          = ws_v;
        i2s_ch0_i         = d0;
        i2s_ch1_i         = d1;
        fifo_data_ready_i = rdy;
        if (fifo_data_valid_o && rdy) pop_q.push_back(fifo_data_o);
        if (cfg_slave_dsp_mode_i) @(posedge sck_i);
        else                      @(negedge sck_i);
        #1;
        ecount++;
        n   = int'(cfg_num_bits_i) + 1;
        occ = (exp_q.size() != 0);
        if (!cfg_en_i) begin
            exp_q.delete();
            exp_err = 1'b0;
        end else begin
            if (rdy && occ) void'(exp_q.pop_front());
            exp_err = done && occ;
            if (done && !occ) begin
                exp_q.push_back(exp_word(w0, n));
                if (cfg_2ch_i) exp_q.push_back(exp_word(w1, n));
            end
        end
        check("valid", fifo_data_valid_o, exp_q.size() != 0);
        if (exp_q.size() != 0) check("data", fifo_data_o, exp_q[0]);
        check("err", fifo_err_o, exp_err);
        if (fifo_err_o) err_pulses++;
        if (fifo_data_valid_o && first_valid < 0 && ws_edge >= 0) first_valid = ecount - ws_edge;
    endtask

    task automatic junk(input logic ws_v);
        step(ws_v, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 32'd0, 32'd0);
    endtask

    task automatic drive_bits(input logic [31:0] w0, input logic [31:0] w1,
                              input logic ws_first, input int cnt);
        int n;
        n = int'(cfg_num_bits_i) + 1;
        for (int j = 0; j < cnt; j++)
            step(ws_first && (j == 0), ser_bit(w0, j), ser_bit(w1, j), j == n - 1, w0, w1);
    endtask

    task automatic run_frame(input int k, input int nw);
        int n;
        n = int'(cfg_num_bits_i) + 1;
        ws_edge = ecount + 1;
        first_valid = -1;
        if (k > 0) begin
            junk(1'b1);
            for (int i = 1; i < k; i++) junk(1'b0);
        end
        for (int i = 0; i < nw; i++) drive_bits(tx0[i], tx1[i], (k == 0) && (i == 0), n);
        drive_bits(tx0[nw], tx1[nw], 1'b0, (n > 2) ? 2 : n);
        ws_edge = -1;
    endtask

    task automatic set_cfg(input logic mode, input logic two, input logic [4:0] nb,
                           input logic lsb, input int off);
        cfg_slave_dsp_mode_i   = mode;
        cfg_2ch_i              = two;
        cfg_num_bits_i         = nb;
        cfg_lsb_first_i        = lsb;
        cfg_slave_dsp_offset_i = 9'(off);
        junk(1'b0);
    endtask

    task automatic enable();
        cfg_en_i = 1'b1;
        junk(1'b0);
        junk(1'b0);
        junk(1'b0);
    endtask

    task automatic disable_ch();
        int saved;
        saved = rdy_mode;
        rdy_mode = 3;
        cfg_en_i = 1'b0;
        junk(1'b0);
        rdy_mode = saved;
    endtask

    task automatic fill_tx(input int cnt);
        tx0.delete();
        tx1.delete();
        for (int i = 0; i < cnt; i++) begin
            tx0.push_back($urandom);
            tx1.push_back($urandom);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        tbl[0] = '{1'b1, 1'b0, 1'b0, 5'd15, 0, 32'h0000A5C3, 32'h0, 32'h0000A5C3, 32'h0, 1, 15};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 5'd31, 3, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 2, 34};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 5'd11, 0, 32'h00000800, 32'h0, EXP_0800, 32'h0, 1, 11};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 5'd7, 5, 32'hFFFFFF3C, 32'h0, 32'h0000003C, 32'h0, 1, 12};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 5'd3, 1, 32'h12345675, 32'hFFFFFFFA, 32'h00000005, EXP_000A, 2, 4};

        rstn_i = 1'b0;
        i2s_ch0_i = 0; i2s_ch1_i = 0; i2s_ws_i = 0; fifo_data_ready_i = 0;
        cfg_en_i = 0; cfg_2ch_i = 0; cfg_num_bits_i = 0; cfg_lsb_first_i = 0;
        cfg_slave_dsp_mode_i = 1; cfg_slave_dsp_offset_i = 0;
        exp_err = 0;
        err_pulses = 0;
        #23;
        check("rst_data", fifo_data_o, 32'h0);
        check("rst_valid", fifo_data_valid_o, 1'b0);
        check("rst_err", fifo_err_o, 1'b0);
        rstn_i = 1'b1;
        #10;

        // Directed vectors
        for (int r = 0; r < 5; r++) begin
            set_cfg(tbl[r].mode, tbl[r].two, tbl[r].nb, tbl[r].lsb, tbl[r].off);
            fill_tx(4);
            tx0[0] = tbl[r].w0;
            tx1[0] = tbl[r].w1;
            pop_q.delete();
            err_pulses = 0;
            rdy_mode = 0;
            enable();
            run_frame(tbl[r].off, 1);
            check("row_latency", first_valid, tbl[r].lat);
            disable_ch();
            check("row_npush", pop_q.size(), tbl[r].npush);
            if (pop_q.size() >= 1) check("row_word0", pop_q[0], tbl[r].e0);
            if (tbl[r].npush == 2 && pop_q.size() >= 2) check("row_word1", pop_q[1], tbl[r].e1);
            check("row_no_err", err_pulses, 0);
        end

        // Overrun: ready low across two word periods, 1ch n=8
        set_cfg(1'b1, 1'b0, 5'd7, 1'b0, 0);
        fill_tx(4);
        tx0[0] = 32'h11; tx0[1] = 32'h22; tx0[2] = 32'h33;
        pop_q.delete();
        err_pulses = 0;
        rdy_mode = 0;
        enable();
        rdy_mode = 2;
        rdy_on_edge = ecount + 1 + 16;
        run_frame(0, 2);
        disable_ch();
        check("ovr_err_pulses", err_pulses, 1);
        check("ovr_npop", pop_q.size(), 1);
        if (pop_q.size() >= 1) check("ovr_word", pop_q[0], 32'h11);

        // Resync: ws at bit 5 of a 16-bit word, then a ws exactly at a word start
        set_cfg(1'b1, 1'b0, 5'd15, 1'b0, 0);
        pop_q.delete();
        err_pulses = 0;
        rdy_mode = 0;
        enable();
        drive_bits(32'h1234, 32'h0, 1'b1, 5);
        drive_bits(32'h4321, 32'h0, 1'b1, 16);
        drive_bits(32'h9ABC, 32'h0, 1'b1, 16);
        drive_bits(32'h0, 32'h0, 1'b0, 2);
        disable_ch();
        check("resync_npop", pop_q.size(), 2);
        if (pop_q.size() >= 2) begin
            check("resync_word0", pop_q[0], 32'h4321);
            check("resync_word1", pop_q[1], 32'h9ABC);
        end
        check("resync_no_err", err_pulses, 0);

        // Enable dropped mid-word, frame syncs while disabled, then re-enabled
        set_cfg(1'b0, 1'b0, 5'd15, 1'b1, 0);
        pop_q.delete();
        err_pulses = 0;
        enable();
        drive_bits(32'h5555, 32'h0, 1'b1, 7);
        disable_ch();
        junk(1'b1);
        junk(1'b0);
        junk(1'b1);
        fill_tx(3);
        tx0[0] = 32'hBEEF;
        enable();
        run_frame(0, 1);
        disable_ch();
        check("en_drop_npop", pop_q.size(), 1);
        if (pop_q.size() >= 1) check("en_drop_word", pop_q[0], 32'hBEEF);
        check("en_drop_no_err", err_pulses, 0);

        // Randomised frames against the reference model
        for (int it = 0; it < 25; it++) begin
            int nw;
            int off;
            nw  = $urandom_range(2, 5);
            off = $urandom_range(0, 12);
            set_cfg(1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom_range(31)),
                    1'($urandom_range(1)), off);
            fill_tx(nw + 1);
            rdy_mode = 1;
            rdy_pct = $urandom_range(40, 100);
            enable();
            run_frame(off, nw);
            disable_ch();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
